alu_seq: RTL

- Registered, handshaked successor to the team's combinational parametrised ALU.
- Adds variable-amount shifts, arithmetic shift right, rotate, and a multi-cycle shift-add multiplier.
- Adds a full NZCV flag set.
- Valid/ready on input and output, so it sits between a decode stage and a writeback stage with back-pressure.

---
 rtl/alu_seq.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered, valid/ready handshaked ALU with NZCV flags.
// Single-cycle ops register their result on the accept edge; MUL runs an
// iterative shift-add over a 2*WIDTH-bit product, one step per cycle.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut,
    output logic             Zero,
    output logic             Negative,
    output logic             Overflow
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0]   WBITS    = (SHW+1)'(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_XOR = 4'b0100,
        OP_NOR = 4'b0101,
        OP_SLL = 4'b0110,
        OP_SRL = 4'b0111,
        OP_SRA = 4'b1000,
        OP_ROL = 4'b1001,
        OP_MUL = 4'b1010
    } op_t;

    state_t state;

    // Shift/rotate amount taken from the low bits of B.
    logic [SHW-1:0] amt;

    // Datapath intermediates, one extra bit to capture carry/shift-out.
    logic [WIDTH:0]        sum_add;
    logic [WIDTH:0]        sum_sub;
    logic [WIDTH:0]        sll_t;
    logic [WIDTH:0]        srl_t;
    logic signed [WIDTH:0] sra_t;
    logic [WIDTH-1:0]      rol_t;

    logic [WIDTH-1:0] res_c;
    logic             carry_c;
    logic             ovf_c;

    // Multiplier state.
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] mul_next;

    assign amt     = B[SHW-1:0];
    assign sum_add = {1'b0, A} + {1'b0, B};
    assign sum_sub = {1'b0, A} - {1'b0, B};
    // SLL: bit WIDTH is the last bit shifted out (A[WIDTH-amt]).
    assign sll_t   = {1'b0, A} << amt;
    // SRL/SRA: bit 0 of the extended vector is the last bit shifted out (A[amt-1]).
    assign srl_t   = {A, 1'b0} >> amt;
    assign sra_t   = $signed({A, 1'b0}) >>> amt;
    // For amt==0 the right-shift term shifts by WIDTH and vanishes, leaving A.
    assign rol_t   = (A << amt) | (A >> (WBITS - {1'b0, amt}));

    assign mul_next = acc + (mplier[0] ? mcand : '0);

    // Combinational result and carry/overflow for all single-cycle ops.
    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (op_t'(ALU_Sel))
            OP_ADD: begin
                res_c   = sum_add[WIDTH-1:0];
                carry_c = sum_add[WIDTH];
                ovf_c   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_add[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                res_c   = sum_sub[WIDTH-1:0];
                carry_c = sum_sub[WIDTH];
                ovf_c   = (A[WIDTH-1] != B[WIDTH-1]) && (sum_sub[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: res_c = A & B;
            OP_OR:  res_c = A | B;
            OP_XOR: res_c = A ^ B;
            OP_NOR: res_c = ~(A | B);
            OP_SLL: begin
                res_c   = sll_t[WIDTH-1:0];
                carry_c = sll_t[WIDTH];
            end
            OP_SRL: begin
                res_c   = srl_t[WIDTH:1];
                carry_c = srl_t[0];
            end
            OP_SRA: begin
                res_c   = sra_t[WIDTH:1];
                carry_c = sra_t[0];
            end
            OP_ROL: begin
                res_c   = rol_t;
                carry_c = (amt != '0) ? rol_t[0] : 1'b0;
            end
            default: begin
                res_c   = '0;
                carry_c = 1'b0;
                ovf_c   = 1'b0;
            end
        endcase
    end

    // Control FSM with registered handshake outputs, result and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Result    <= '0;
            CarryOut  <= 1'b0;
            Zero      <= 1'b0;
            Negative  <= 1'b0;
            Overflow  <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (ALU_Sel == OP_MUL) begin
                            mcand  <= {{WIDTH{1'b0}}, A};
                            mplier <= B;
                            acc    <= '0;
                            cnt    <= '0;
                            state  <= MUL;
                        end else begin
                            Result    <= res_c;
                            CarryOut  <= carry_c;
                            Overflow  <= ovf_c;
                            Zero      <= (res_c == '0);
                            Negative  <= res_c[WIDTH-1];
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                MUL: begin
                    acc    <= mul_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + SHW'(1);
                    if (cnt == CNT_LAST) begin
                        Result    <= mul_next[WIDTH-1:0];
                        CarryOut  <= |mul_next[2*WIDTH-1:WIDTH];
                        Overflow  <= 1'b0;
                        Zero      <= (mul_next[WIDTH-1:0] == '0);
                        Negative  <= mul_next[WIDTH-1];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
